// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one external combinational ALU between two requesters. At most one
//   operation is issued per cycle. Each requester owns a one-entry response
//   buffer that captures the ALU result on the edge ending its grant cycle.
//
// Parameters
//   RR_EN            1 = round-robin on contention, 0 = requester 0 always wins
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready      request handshake (ready is the same-cycle grant)
//   reqN_a, reqN_b               32-bit operands
//   reqN_alucont                 4-bit ALU control
//   reqN_sltunsigned             unsigned-compare select
//   respN_valid / respN_ready    response handshake (valid is registered)
//   respN_result                 buffered 32-bit result
//   alu_a, alu_b, alu_alucont,
//   alu_sltunsigned              operands and control to the shared ALU
//   alu_result                   combinational result from the shared ALU
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_alucont,
    input  logic        req0_sltunsigned,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [31:0] resp0_result,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_alucont,
    input  logic        req1_sltunsigned,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp1_result,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_alucont,
    output logic        alu_sltunsigned,
    input  logic [31:0] alu_result
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t  st0, st1;
    logic [31:0] result0_q, result1_q;
    logic        last_q;      // 0 = requester 0 granted most recently, 1 = requester 1
    logic        elig0, elig1;
    logic        gnt0, gnt1;

    // A FULL buffer being drained this cycle can accept a new result at the
    // same edge, so it counts as eligible. Gating with reset_n keeps ready and
    // the ALU bus quiet while reset is held, independent of the clock.
    always_comb begin
        elig0 = reset_n && req0_valid && ((st0 == EMPTY) || resp0_ready);
        elig1 = reset_n && req1_valid && ((st1 == EMPTY) || resp1_ready);

        // On contention requester 0 wins if fixed priority is selected or if
        // requester 1 was the most recent winner.
        gnt0 = elig0 && (!elig1 || !RR_EN || last_q);
        gnt1 = elig1 && !gnt0;

        alu_a           = '0;
        alu_b           = '0;
        alu_alucont     = '0;
        alu_sltunsigned = 1'b0;
        if (gnt0) begin
            alu_a           = req0_a;
            alu_b           = req0_b;
            alu_alucont     = req0_alucont;
            alu_sltunsigned = req0_sltunsigned;
        end else if (gnt1) begin
            alu_a           = req1_a;
            alu_b           = req1_b;
            alu_alucont     = req1_alucont;
            alu_sltunsigned = req1_sltunsigned;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st0       <= EMPTY;
            st1       <= EMPTY;
            result0_q <= '0;
            result1_q <= '0;
            last_q    <= 1'b1;
        end else begin
            if (gnt0) begin
                st0       <= FULL;
                result0_q <= alu_result;
            end else if (resp0_ready) begin
                st0 <= EMPTY;
            end

            if (gnt1) begin
                st1       <= FULL;
                result1_q <= alu_result;
            end else if (resp1_ready) begin
                st1 <= EMPTY;
            end

            if (gnt0) begin
                last_q <= 1'b0;
            end else if (gnt1) begin
                last_q <= 1'b1;
            end
        end
    end

    assign resp0_valid  = (st0 == FULL);
    assign resp1_valid  = (st1 == FULL);
    assign resp0_result = result0_q;
    assign resp1_result = result1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Two arbiter instances (round-robin and fixed priority) share one set of
//   requester inputs; each has its own behavioural ALU on its alu_* bus.
module tb_alu_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_alucont, req1_alucont;
    logic        req0_sltunsigned, req1_sltunsigned;
    logic        resp0_ready, resp1_ready;

    logic        rr_req0_ready, rr_req1_ready, rr_resp0_valid, rr_resp1_valid;
    logic [31:0] rr_resp0_result, rr_resp1_result, rr_alu_a, rr_alu_b, rr_alu_result;
    logic [3:0]  rr_alu_alucont;
    logic        rr_alu_sltunsigned;

    logic        fp_req0_ready, fp_req1_ready, fp_resp0_valid, fp_resp1_valid;
    logic [31:0] fp_resp0_result, fp_resp1_result, fp_alu_a, fp_alu_b, fp_alu_result;
    logic [3:0]  fp_alu_alucont;
    logic        fp_alu_sltunsigned;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] c, input logic u);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return u ? {31'd0, (a < b)} : {31'd0, ($signed(a) < $signed(b))};
            4'b1000: return a ^ b;
            default: return '0;
        endcase
    endfunction

    assign rr_alu_result = alu_model(rr_alu_a, rr_alu_b, rr_alu_alucont, rr_alu_sltunsigned);
    assign fp_alu_result = alu_model(fp_alu_a, fp_alu_b, fp_alu_alucont, fp_alu_sltunsigned);

    alu_arbiter #(.RR_EN(1'b1)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(rr_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_alucont(req0_alucont),
        .req0_sltunsigned(req0_sltunsigned),
        .resp0_valid(rr_resp0_valid), .resp0_ready(resp0_ready), .resp0_result(rr_resp0_result),
        .req1_valid(req1_valid), .req1_ready(rr_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_alucont(req1_alucont),
        .req1_sltunsigned(req1_sltunsigned),
        .resp1_valid(rr_resp1_valid), .resp1_ready(resp1_ready), .resp1_result(rr_resp1_result),
        .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_alucont(rr_alu_alucont),
        .alu_sltunsigned(rr_alu_sltunsigned), .alu_result(rr_alu_result)
    );

    alu_arbiter #(.RR_EN(1'b0)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_alucont(req0_alucont),
        .req0_sltunsigned(req0_sltunsigned),
        .resp0_valid(fp_resp0_valid), .resp0_ready(resp0_ready), .resp0_result(fp_resp0_result),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_alucont(req1_alucont),
        .req1_sltunsigned(req1_sltunsigned),
        .resp1_valid(fp_resp1_valid), .resp1_ready(resp1_ready), .resp1_result(fp_resp1_result),
        .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_alucont(fp_alu_alucont),
        .alu_sltunsigned(fp_alu_sltunsigned), .alu_result(fp_alu_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_a = '0; req0_b = '0; req0_alucont = '0; req0_sltunsigned = 0;
        req1_a = '0; req1_b = '0; req1_alucont = '0; req1_sltunsigned = 0;
        resp0_ready = 1; resp1_ready = 1;
    endtask

    // Leaves the bench at a falling edge with reset released and inputs idle.
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
    endtask

    typedef struct {
        logic        v0;
        logic [31:0] a0, b0;
        logic [3:0]  c0;
        logic        u0;
        logic        v1;
        logic [31:0] a1, b1;
        logic [3:0]  c1;
        logic        u1;
        logic        e_rdy0, e_rdy1;
        logic        e_val0;
        logic [31:0] e_res0;
        logic        e_val1;
        logic [31:0] e_res1;
    } vec_t;

    vec_t vecs[10];

    initial begin
        reset_n = 0;
        clear_inputs();

        //          v0  a0            b0            c0       u0  v1  a1            b1            c1       u1  r0 r1 val0 res0          val1 res1
        vecs[0] = '{1, 32'd5,        32'd7,        4'b0010, 0,  0, 32'd0,        32'd0,        4'b0000, 0,  1, 0, 1, 32'h0000000C, 0, 32'h0};
        vecs[1] = '{0, 32'd0,        32'd0,        4'b0000, 0,  1, 32'd3,        32'd5,        4'b0110, 0,  0, 1, 0, 32'h0,        1, 32'hFFFFFFFE};
        vecs[2] = '{1, 32'hFFFFFFFF, 32'd1,        4'b0111, 0,  0, 32'd0,        32'd0,        4'b0000, 0,  1, 0, 1, 32'h00000001, 0, 32'h0};
        vecs[3] = '{1, 32'hFFFFFFFF, 32'd1,        4'b0111, 1,  0, 32'd0,        32'd0,        4'b0000, 0,  1, 0, 1, 32'h00000000, 0, 32'h0};
        vecs[4] = '{0, 32'd0,        32'd0,        4'b0000, 0,  1, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 0,  0, 1, 0, 32'h0,        1, 32'hF000F000};
        vecs[5] = '{1, 32'h0000FFFF, 32'h12340000, 4'b0001, 0,  0, 32'd0,        32'd0,        4'b0000, 0,  1, 0, 1, 32'h1234FFFF, 0, 32'h0};
        vecs[6] = '{0, 32'd0,        32'd0,        4'b0000, 0,  1, 32'hAAAAAAAA, 32'hFFFFFFFF, 4'b1000, 0,  0, 1, 0, 32'h0,        1, 32'h55555555};
        vecs[7] = '{1, 32'hFFFFFFFF, 32'd1,        4'b0010, 0,  1, 32'd16,       32'd1,        4'b0110, 0,  1, 0, 1, 32'h00000000, 0, 32'h0};
        vecs[8] = '{0, 32'd9,        32'd9,        4'b0010, 0,  0, 32'd9,        32'd9,        4'b0010, 0,  0, 0, 0, 32'h0,        0, 32'h0};
        vecs[9] = '{0, 32'd0,        32'd0,        4'b0000, 0,  1, 32'd1,        32'hFFFFFFFF, 4'b0111, 1,  0, 1, 0, 32'h0,        1, 32'h00000001};

        // reset state
        @(negedge clk);
        req0_valid = 1; req1_valid = 1; req0_a = 32'h1234; req0_alucont = 4'b0010;
        #1;
        check("reset resp0_valid", {31'd0, rr_resp0_valid}, 32'd0);
        check("reset resp1_valid", {31'd0, rr_resp1_valid}, 32'd0);
        check("reset resp0_result", rr_resp0_result, 32'd0);
        check("reset req0_ready", {31'd0, rr_req0_ready}, 32'd0);
        check("reset alu_a", rr_alu_a, 32'd0);

        // table-driven vectors, each from a fresh reset
        for (int i = 0; i < 10; i++) begin
            do_reset();
            req0_valid = vecs[i].v0; req0_a = vecs[i].a0; req0_b = vecs[i].b0;
            req0_alucont = vecs[i].c0; req0_sltunsigned = vecs[i].u0;
            req1_valid = vecs[i].v1; req1_a = vecs[i].a1; req1_b = vecs[i].b1;
            req1_alucont = vecs[i].c1; req1_sltunsigned = vecs[i].u1;
            #1;
            check($sformatf("vec%0d req0_ready", i), {31'd0, rr_req0_ready}, {31'd0, vecs[i].e_rdy0});
            check($sformatf("vec%0d req1_ready", i), {31'd0, rr_req1_ready}, {31'd0, vecs[i].e_rdy1});
            if (vecs[i].e_rdy0)
                check($sformatf("vec%0d alu_a", i), rr_alu_a, vecs[i].a0);
            else if (vecs[i].e_rdy1)
                check($sformatf("vec%0d alu_a", i), rr_alu_a, vecs[i].a1);
            else begin
                check($sformatf("vec%0d idle alu_a", i), rr_alu_a, 32'd0);
                check($sformatf("vec%0d idle alu_alucont", i), {28'd0, rr_alu_alucont}, 32'd0);
            end
            @(posedge clk); #1;
            req0_valid = 0; req1_valid = 0;
            check($sformatf("vec%0d resp0_valid", i), {31'd0, rr_resp0_valid}, {31'd0, vecs[i].e_val0});
            check($sformatf("vec%0d resp0_result", i), rr_resp0_result, vecs[i].e_res0);
            check($sformatf("vec%0d resp1_valid", i), {31'd0, rr_resp1_valid}, {31'd0, vecs[i].e_val1});
            check($sformatf("vec%0d resp1_result", i), rr_resp1_result, vecs[i].e_res1);
        end

        // continuous contention: RR alternates 0,1,0,1; fixed priority always 0
        do_reset();
        req0_valid = 1; req0_a = 32'd1; req0_b = 32'd2; req0_alucont = 4'b0010;
        req1_valid = 1; req1_a = 32'd8; req1_b = 32'd3; req1_alucont = 4'b0110;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("rr cyc%0d req0_ready", i), {31'd0, rr_req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr cyc%0d req1_ready", i), {31'd0, rr_req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("fp cyc%0d req0_ready", i), {31'd0, fp_req0_ready}, 32'd1);
            check($sformatf("fp cyc%0d req1_ready", i), {31'd0, fp_req1_ready}, 32'd0);
            @(negedge clk);
        end
        #1;
        check("rr alt resp0_result", rr_resp0_result, 32'd3);
        check("rr alt resp1_result", rr_resp1_result, 32'd5);

        // backpressure: FULL buffer not drained blocks a new grant and holds data
        do_reset();
        resp0_ready = 0;
        req0_valid = 1; req0_a = 32'd1; req0_b = 32'd1; req0_alucont = 4'b0010;
        #1;
        check("bp first req0_ready", {31'd0, rr_req0_ready}, 32'd1);
        @(negedge clk);
        req0_a = 32'd2; req0_b = 32'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp hold%0d req0_ready", i), {31'd0, rr_req0_ready}, 32'd0);
            check($sformatf("bp hold%0d resp0_valid", i), {31'd0, rr_resp0_valid}, 32'd1);
            check($sformatf("bp hold%0d resp0_result", i), rr_resp0_result, 32'd2);
            @(negedge clk);
        end
        resp0_ready = 1;
        #1;
        check("bp drain req0_ready", {31'd0, rr_req0_ready}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 0;
        check("bp drain resp0_valid", {31'd0, rr_resp0_valid}, 32'd1);
        check("bp drain resp0_result", rr_resp0_result, 32'd4);

        // asynchronous reset with both buffers FULL
        do_reset();
        resp0_ready = 0; resp1_ready = 0;
        req0_valid = 1; req0_a = 32'd5; req0_b = 32'd7; req0_alucont = 4'b0010;
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 1; req1_a = 32'd3; req1_b = 32'd5; req1_alucont = 4'b0110;
        @(negedge clk);
        req1_valid = 0;
        #1;
        check("ar pre resp0_valid", {31'd0, rr_resp0_valid}, 32'd1);
        check("ar pre resp1_valid", {31'd0, rr_resp1_valid}, 32'd1);
        check("ar pre resp1_result", rr_resp1_result, 32'hFFFFFFFE);
        req0_valid = 1; req1_valid = 1; resp0_ready = 1; resp1_ready = 1;
        reset_n = 0;
        #1;
        check("ar resp0_valid", {31'd0, rr_resp0_valid}, 32'd0);
        check("ar resp1_valid", {31'd0, rr_resp1_valid}, 32'd0);
        check("ar resp0_result", rr_resp0_result, 32'd0);
        check("ar req0_ready", {31'd0, rr_req0_ready}, 32'd0);
        check("ar req1_ready", {31'd0, rr_req1_ready}, 32'd0);
        check("ar alu_a", rr_alu_a, 32'd0);
        @(negedge clk);
        reset_n = 1;
        #1;
        check("ar post req0_ready", {31'd0, rr_req0_ready}, 32'd1);
        check("ar post req1_ready", {31'd0, rr_req1_ready}, 32'd0);
        @(posedge clk); #1;
        check("ar post resp0_result", rr_resp0_result, 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin between requesters, 0 = fixed priority to requester 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  operation of requester N accepted this cycle.
REQ-006 reqN_a, reqN_b  input  32 each  operands of requester N.
REQ-007 reqN_alucont  input  4  ALU control of requester N (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 XOR).
REQ-008 reqN_sltunsigned  input  1  unsigned-compare select of requester N.
REQ-009 respN_valid  output  1  result for requester N held in its buffer.
REQ-010 respN_ready  input  1  requester N consumes its result.
REQ-011 respN_result  output  32  result for requester N.
REQ-012 alu_a, alu_b  output  32 each  operands to the shared ALU.
REQ-013 alu_alucont  output  4; alu_sltunsigned  output  1  control to the shared ALU.
REQ-014 alu_result  input  32  combinational result from the shared ALU.

Function
REQ-015 The block SHALL share one combinational ALU between two requesters, at most one operation per cycle.
REQ-016 Each requester SHALL own a one-entry response buffer with states EMPTY and FULL.
REQ-017 Requester N SHALL be eligible when reqN_valid=1 and its buffer is EMPTY, or FULL with respN_ready=1 that cycle.
REQ-018 Exactly one eligible requester SHALL be granted; grant drives reqN_ready=1 combinationally in the same cycle.
REQ-019 With both eligible: RR_EN=1 grants the requester not granted most recently; RR_EN=0 always grants requester 0.
REQ-020 The last-granted pointer SHALL update only on a grant.
REQ-021 alu_* outputs SHALL mirror the granted request's operands and control; with no grant they SHALL be all zero.
REQ-022 On a grant, alu_result SHALL be captured into the granted buffer at the clock edge; respN_valid=1 and respN_result valid the following cycle (latency 1).
REQ-023 Buffer transitions: EMPTY->FULL on grant; FULL->EMPTY on respN_ready without grant; FULL->FULL with new data on simultaneous respN_ready and grant.
REQ-024 respN_result SHALL remain stable while respN_valid=1 and respN_ready=0.
REQ-025 A requester holding reqN_valid=1 with reqN_ready=0 SHALL keep its payload stable; the block samples payload only when granted.
REQ-026 respN_valid SHALL not depend combinationally on any input.
REQ-027 With RR_EN=1 and both continuously eligible, grants SHALL alternate every cycle; neither requester starves.

Reset
REQ-028 While reset_n=0: both buffers EMPTY, respN_valid=0, respN_result=0, pointer = requester 1 (requester 0 wins first contention).
REQ-029 While reset_n=0, reqN_ready=0 and alu_* outputs SHALL be zero regardless of inputs.
REQ-030 Reset asserted mid-operation SHALL discard buffered results immediately without waiting for a clock edge.

Verification
REQ-031 req0 ADD a=5 b=7 alucont=0010, resp0_ready=1 -> req0_ready=1 same cycle; next cycle resp0_valid=1, resp0_result=0000000C.
REQ-032 req1 SUB a=3 b=5 alucont=0110 -> resp1_result=FFFFFFFE one cycle later; req0 idle, resp0_valid stays 0.
REQ-033 SLT alucont=0111 a=FFFFFFFF b=00000001: sltunsigned=0 -> result 00000001; sltunsigned=1 -> result 00000000.
REQ-034 Both valid every cycle, RR_EN=1, both resp_ready=1, after reset -> grants 0,1,0,1...; RR_EN=0 -> grants 0,0,0...
REQ-035 resp0_ready=0 with resp0 buffer FULL and req0_valid=1 -> req0_ready=0, resp0_result held; raising resp0_ready -> drain and new grant same cycle.
REQ-036 reset_n pulled low asynchronously with both buffers FULL -> respN_valid=0 before next edge; first post-reset contention grants requester 0.
